// File: rtl/pong_match_sequencer.sv
// Match-level sequencer for the pong ball datapath: serve countdown, rally
// speed-up, point pause and game-over handling, all outputs registered.
module pong_match_sequencer #(
  parameter int          SERVE_TICKS   = 60,
  parameter int          POINT_TICKS   = 90,
  parameter int          VEL_INIT      = 2,
  parameter int          VEL_MAX       = 7,
  parameter int          HITS_PER_STEP = 4,
  parameter logic [3:0]  LFSR_SEED     = 4'b1001
) (
  input  logic       game_clk,
  input  logic       reset,
  input  logic       start,
  input  logic       wall_col,
  input  logic       paddle_col,
  input  logic       x_ball_dir,
  input  logic       lossA,
  input  logic       lossB,
  output logic       ball_hold,
  output logic       clear_scores,
  output logic       serve_dir,
  output logic [3:0] x_ball_vel,
  output logic [3:0] y_ball_vel,
  output logic [2:0] state,
  output logic [7:0] rally_hits,
  output logic [1:0] winner
);

  localparam int DWELL_MAX = (SERVE_TICKS > POINT_TICKS) ? SERVE_TICKS : POINT_TICKS;
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);
  localparam int HIT_W     = (HITS_PER_STEP > 1) ? $clog2(HITS_PER_STEP) : 1;

  localparam logic [CNT_W-1:0] SERVE_LOAD = CNT_W'(SERVE_TICKS - 1);
  localparam logic [CNT_W-1:0] POINT_LOAD = CNT_W'(POINT_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [HIT_W-1:0] HIT_LAST   = HIT_W'(HITS_PER_STEP - 1);
  localparam logic [HIT_W-1:0] HIT_ONE    = HIT_W'(1);
  localparam logic [3:0]       VEL_INIT_V = 4'(VEL_INIT);
  localparam logic [3:0]       VEL_MAX_V  = 4'(VEL_MAX);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SERVE = 3'd2,
    RALLY = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] dwell_reg;
  logic [HIT_W-1:0] hit_cnt_reg;
  logic [3:0]       lfsr_reg;
  logic             armed_reg;
  logic             ball_hold_reg;
  logic             clear_scores_reg;
  logic             serve_dir_reg;
  logic [3:0]       x_ball_vel_reg;
  logic [3:0]       y_ball_vel_reg;
  logic [7:0]       rally_hits_reg;
  logic [1:0]       winner_reg;

  logic [3:0] lfsr_next;
  logic [3:0] y_pick;
  logic [3:0] x_step;
  logic [7:0] hits_inc;

  // x^4 + x^3 + 1: feedback from the two top bits, shifted in at bit 0.
  assign lfsr_next[0] = lfsr_reg[3] ^ lfsr_reg[2];
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lfsr_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  assign y_pick   = {2'b00, lfsr_reg[1:0]} + 4'd1;
  assign x_step   = (x_ball_vel_reg >= VEL_MAX_V) ? VEL_MAX_V : x_ball_vel_reg + 4'd1;
  assign hits_inc = (rally_hits_reg == 8'hFF) ? 8'hFF : rally_hits_reg + 8'd1;

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      dwell_reg        <= '0;
      hit_cnt_reg      <= '0;
      lfsr_reg         <= LFSR_SEED;
      armed_reg        <= 1'b0;
      ball_hold_reg    <= 1'b1;
      clear_scores_reg <= 1'b0;
      serve_dir_reg    <= 1'b1;
      x_ball_vel_reg   <= 4'd0;
      y_ball_vel_reg   <= 4'd0;
      rally_hits_reg   <= 8'd0;
      winner_reg       <= 2'b00;
    end else begin
      lfsr_reg         <= lfsr_next;
      clear_scores_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg        <= CLEAR;
            clear_scores_reg <= 1'b1;
            winner_reg       <= 2'b00;
            serve_dir_reg    <= 1'b1;
          end
        end
        CLEAR: begin
          state_reg <= SERVE;
          dwell_reg <= SERVE_LOAD;
        end
        SERVE: begin
          if (dwell_reg == '0) begin
            state_reg      <= RALLY;
            ball_hold_reg  <= 1'b0;
            x_ball_vel_reg <= VEL_INIT_V;
            y_ball_vel_reg <= y_pick;
            rally_hits_reg <= 8'd0;
            hit_cnt_reg    <= '0;
          end else begin
            dwell_reg <= dwell_reg - CNT_ONE;
          end
        end
        RALLY: begin
          // A goal in the same tick as a paddle hit ends the rally uncounted.
          if (wall_col) begin
            state_reg      <= POINT;
            dwell_reg      <= POINT_LOAD;
            serve_dir_reg  <= ~x_ball_dir;
            ball_hold_reg  <= 1'b1;
            x_ball_vel_reg <= 4'd0;
            y_ball_vel_reg <= 4'd0;
          end else if (paddle_col) begin
            rally_hits_reg <= hits_inc;
            if (hit_cnt_reg == HIT_LAST) begin
              hit_cnt_reg    <= '0;
              x_ball_vel_reg <= x_step;
              y_ball_vel_reg <= y_pick;
            end else begin
              hit_cnt_reg <= hit_cnt_reg + HIT_ONE;
            end
          end
        end
        POINT: begin
          if (dwell_reg == '0) begin
            if (lossA) begin
              state_reg  <= OVER;
              winner_reg <= 2'b01;
              armed_reg  <= 1'b0;
            end else if (lossB) begin
              state_reg  <= OVER;
              winner_reg <= 2'b10;
              armed_reg  <= 1'b0;
            end else begin
              state_reg <= SERVE;
              dwell_reg <= SERVE_LOAD;
            end
          end else begin
            dwell_reg <= dwell_reg - CNT_ONE;
          end
        end
        OVER: begin
          // Restart needs start released inside OVER before it counts again.
          if (armed_reg && start) begin
            state_reg        <= CLEAR;
            clear_scores_reg <= 1'b1;
            winner_reg       <= 2'b00;
            serve_dir_reg    <= 1'b1;
          end else if (!start) begin
            armed_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign state        = state_reg;
  assign ball_hold    = ball_hold_reg;
  assign clear_scores = clear_scores_reg;
  assign serve_dir    = serve_dir_reg;
  assign x_ball_vel   = x_ball_vel_reg;
  assign y_ball_vel   = y_ball_vel_reg;
  assign rally_hits   = rally_hits_reg;
  assign winner       = winner_reg;

endmodule
